// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bit indices,
// MEM-stage FSM encoding and the MEM/WB bundle.
package mips_pkg;

   localparam int M_BRANCH   = 2;
   localparam int M_MEMREAD  = 1;
   localparam int M_MEMWRITE = 0;

   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef struct packed {
      logic [1:0]  wb;
      logic [31:0] dato;
      logic [31:0] alu;
      logic [4:0]  mux;
   } mem_wb_t;

   function automatic logic is_memop(
      input logic [2:0] m
   );
      return m[M_MEMREAD] | m[M_MEMWRITE];
   endfunction

endpackage

// File: rtl/data_ram_sp.sv
// Single-port synchronous data RAM, read-first,
// read data registered one cycle after the address.
module data_ram_sp #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_stage_mw.sv
// MEM stage: branch resolution, multi-cycle data access
// and the MEM/WB pipeline register.
module mem_stage_mw
   import mips_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  MEM_WB,
   input  logic [2:0]  MEM_M,
   input  logic [31:0] MEM_SumRes,
   input  logic        MEM_ZFlag,
   input  logic [31:0] MEM_ALURes,
   input  logic [31:0] MEM_DatoLeidoB,
   input  logic [4:0]  MEM_MUXRes,
   output logic        MEM_PCSrc,
   output logic [31:0] MEM_BranchTarget,
   output logic        MEM_Stall,
   output logic        MEM_Misaligned,
   output logic [1:0]  MEMWB_WBout,
   output logic [31:0] MEMWB_DatoLeidoout,
   output logic [31:0] MEMWB_ALUResout,
   output logic [4:0]  MEMWB_MUXResout
);

   localparam int CW =
      (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
   localparam logic HAS_LAT = (MEM_LAT > 0);

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              rd_q, wr_q;
   mem_wb_t           mw_q, mw_d;
   logic              sel_ram_q, sel_ram_d;

   logic              in_idle, memop, misal, req;
   logic [ADDR_W-1:0] idx;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata, ram_rdata;
   logic              unused_bits;

   assign idx         = MEM_ALURes[ADDR_W+1:2];
   assign unused_bits = ^MEM_ALURes[31:ADDR_W+2];

   assign in_idle = (state_q == ST_IDLE);
   assign memop   = in_idle & is_memop(MEM_M);
   assign misal   = memop & (MEM_ALURes[1:0] != 2'b00);
   assign req     = memop & ~misal;

   assign MEM_Stall = ~rst &
      ((req & HAS_LAT) | (state_q == ST_WAIT));
   assign MEM_Misaligned   = ~rst & misal;
   assign MEM_PCSrc        = ~rst & MEM_M[M_BRANCH]
                           & MEM_ZFlag & ~MEM_Stall;
   assign MEM_BranchTarget = MEM_SumRes;

   // Request cycle drives the live address; later cycles the latched one
   assign ram_addr  = in_idle ? idx : addr_q;
   assign ram_wdata = in_idle ? MEM_DatoLeidoB : wdata_q;
   assign ram_we    = ~rst & (HAS_LAT ?
      ((state_q == ST_DONE) & wr_q) :
      (req & MEM_M[M_MEMWRITE]));

   data_ram_sp #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mw_d      = '0;
      sel_ram_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (misal) begin
               mw_d = '0;
            end else if (req && HAS_LAT) begin
               state_d = (MEM_LAT == 1) ? ST_DONE : ST_WAIT;
               cnt_d   = CW'(MEM_LAT - 1);
            end else begin
               mw_d.wb  = MEM_WB;
               mw_d.alu = MEM_ALURes;
               mw_d.mux = MEM_MUXRes;
               if (req && MEM_M[M_MEMWRITE]) begin
                  mw_d.dato = MEM_M[M_MEMREAD] ?
                     MEM_DatoLeidoB : 32'h0;
               end else if (req) begin
                  sel_ram_d = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d  = ST_IDLE;
            mw_d.wb  = MEM_WB;
            mw_d.alu = MEM_ALURes;
            mw_d.mux = MEM_MUXRes;
            if (rd_q) begin
               mw_d.dato = wr_q ? wdata_q : ram_rdata;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         mw_q      <= '0;
         sel_ram_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mw_q      <= mw_d;
         sel_ram_q <= sel_ram_d;
         if (req) begin
            addr_q  <= idx;
            wdata_q <= MEM_DatoLeidoB;
            rd_q    <= MEM_M[M_MEMREAD];
            wr_q    <= MEM_M[M_MEMWRITE];
         end
      end
   end

   // Single-cycle loads take the RAM's own output register
   assign MEMWB_WBout        = mw_q.wb;
   assign MEMWB_DatoLeidoout = sel_ram_q ? ram_rdata : mw_q.dato;
   assign MEMWB_ALUResout    = mw_q.alu;
   assign MEMWB_MUXResout    = mw_q.mux;

endmodule

// File: tb/tb_mem_stage_mw.sv
// Bench for mem_stage_mw: a MEM_LAT=2 and a MEM_LAT=0
// instance against a word-array reference model.
module tb_mem_stage_mw;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  wb;
   logic [2:0]  m;
   logic [31:0] sum, alu, db;
   logic        z;
   logic [4:0]  mux;
   logic        sel0;
   logic [2:0]  m2, m0;

   assign m2 = sel0 ? 3'b000 : m;
   assign m0 = sel0 ? m : 3'b000;

   logic        pcs2, pcs0, stl2, stl0, mis2, mis0;
   logic [31:0] btg2, btg0, dto2, dto0, alo2, alo0;
   logic [1:0]  wbo2, wbo0;
   logic [4:0]  mxo2, mxo0;

   mem_stage_mw #(.ADDR_W(8), .MEM_LAT(2)) u_dut2 (
      .clk(clk), .rst(rst), .MEM_WB(wb), .MEM_M(m2),
      .MEM_SumRes(sum), .MEM_ZFlag(z), .MEM_ALURes(alu),
      .MEM_DatoLeidoB(db), .MEM_MUXRes(mux),
      .MEM_PCSrc(pcs2), .MEM_BranchTarget(btg2),
      .MEM_Stall(stl2), .MEM_Misaligned(mis2),
      .MEMWB_WBout(wbo2), .MEMWB_DatoLeidoout(dto2),
      .MEMWB_ALUResout(alo2), .MEMWB_MUXResout(mxo2)
   );

   mem_stage_mw #(.ADDR_W(8), .MEM_LAT(0)) u_dut0 (
      .clk(clk), .rst(rst), .MEM_WB(wb), .MEM_M(m0),
      .MEM_SumRes(sum), .MEM_ZFlag(z), .MEM_ALURes(alu),
      .MEM_DatoLeidoB(db), .MEM_MUXRes(mux),
      .MEM_PCSrc(pcs0), .MEM_BranchTarget(btg0),
      .MEM_Stall(stl0), .MEM_Misaligned(mis0),
      .MEMWB_WBout(wbo0), .MEMWB_DatoLeidoout(dto0),
      .MEMWB_ALUResout(alo0), .MEMWB_MUXResout(mxo0)
   );

   int total = 0;
   int bad   = 0;
   int wcount = 0;

   always @(negedge clk) begin
      if (u_dut2.ram_we === 1'b1) wcount++;
   end

   // Reference memory: [0] for MEM_LAT=2, [1] for MEM_LAT=0
   logic [31:0] mem [2][256];
   bit          vld [2][256];

   typedef struct {
      int          nst;
      logic        mis;
      logic        pcf;
      logic        pcl;
      logic [1:0]  w;
      logic [31:0] d;
      logic [31:0] a;
      logic [4:0]  r;
      bit          dchk;
   } exp_t;

   function automatic exp_t model(
      input bit s0, input logic [1:0] w,
      input logic [2:0] mm, input logic [31:0] a,
      input logic [31:0] d, input logic [4:0] r,
      input logic zz
   );
      exp_t e;
      int u;
      int k;
      bit op;
      u  = s0 ? 1 : 0;
      k  = int'(a[9:2]);
      op = mm[1] | mm[0];
      e.mis  = op && (a[1:0] != 2'b00);
      e.dchk = 1'b1;
      if (e.mis) begin
         e.nst = 0; e.w = 0; e.d = 0; e.a = 0; e.r = 0;
      end else begin
         e.nst = op ? (s0 ? 0 : 2) : 0;
         e.w = w; e.a = a; e.r = r; e.d = 0;
         if (mm[0]) begin
            mem[u][k] = d;
            vld[u][k] = 1'b1;
         end
         if (mm[1]) begin
            e.d    = mem[u][k];
            e.dchk = vld[u][k];
         end
      end
      e.pcl = mm[2] & zz;
      e.pcf = mm[2] & zz & (e.nst == 0);
      return e;
   endfunction

   int          r_nst;
   logic        r_pcf, r_pcl, r_mis;
   logic [1:0]  r_w;
   logic [31:0] r_d, r_a;
   logic [4:0]  r_r;

   // Drive one instruction and hold it until the stage accepts it
   task automatic run_op(
      input bit s0, input logic [1:0] w,
      input logic [2:0] mm, input logic [31:0] a,
      input logic [31:0] d, input logic [4:0] r,
      input logic zz, input bit scr
   );
      logic st, p;
      bit tmo;
      wb = w; m = mm; alu = a; db = d; mux = r;
      z = zz; sel0 = s0; sum = $urandom;
      r_nst = 0; tmo = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         st = s0 ? stl0 : stl2;
         p  = s0 ? pcs0 : pcs2;
         if (c == 0) begin
            r_pcf = p;
            r_mis = s0 ? mis0 : mis2;
         end
         r_pcl = p;
         @(posedge clk);
         #1;
         if (scr && c == 0) db = $urandom;
         if (!st) begin
            tmo = 1'b0;
            break;
         end
         r_nst++;
      end
      total++;
      if (tmo) begin
         bad++;
         $display("FAIL op_timeout got=stuck want=accept");
      end
      r_w = s0 ? wbo0 : wbo2;
      r_d = s0 ? dto0 : dto2;
      r_a = s0 ? alo0 : alo2;
      r_r = s0 ? mxo0 : mxo2;
      m = 3'b000;
   endtask

   task automatic test_reset();
      rst = 1'b1; sel0 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         wb = 2'($urandom); m = 3'($urandom);
         sum = $urandom; z = 1'($urandom);
         alu = $urandom; db = $urandom;
         mux = 5'($urandom);
         @(negedge clk);
         total++;
         if ({wbo2, dto2, alo2, mxo2} !== '0) begin
            bad++;
            $display("FAIL rst_memwb got=%h want=0",
               {wbo2, dto2, alo2, mxo2});
         end
         total++;
         if ({stl2, pcs2} !== 2'b00) begin
            bad++;
            $display("FAIL rst_stall_pc got=%b want=00",
               {stl2, pcs2});
         end
         total++;
         if ({wbo0, dto0, alo0, mxo0} !== '0) begin
            bad++;
            $display("FAIL rst_memwb0 got=%h want=0",
               {wbo0, dto0, alo0, mxo0});
         end
      end
      rst = 1'b0; m = 3'b000; z = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_store_load();
      exp_t e;
      wcount = 0;
      e = model(0, 2'b00, 3'b001, 32'h10,
         32'hDEADBEEF, 5'd0, 1'b0);
      run_op(0, 2'b00, 3'b001, 32'h10,
         32'hDEADBEEF, 5'd0, 1'b0, 1'b1);
      total++;
      if (r_nst !== 2) begin
         bad++;
         $display("FAIL st_stall got=%0d want=2", r_nst);
      end
      e = model(0, 2'b11, 3'b010, 32'h10, 32'h0, 5'd7, 1'b0);
      run_op(0, 2'b11, 3'b010, 32'h10, 32'h0, 5'd7, 1'b0, 1'b0);
      total++;
      if (r_nst !== 2) begin
         bad++;
         $display("FAIL ld_stall got=%0d want=2", r_nst);
      end
      total++;
      if (r_d !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL ld_data got=%h want=deadbeef", r_d);
      end
      total++;
      if ({r_w, r_r} !== {2'b11, 5'd7}) begin
         bad++;
         $display("FAIL ld_ctl got=%h want=%h",
            {r_w, r_r}, {2'b11, 5'd7});
      end
      total++;
      if (wcount !== 1) begin
         bad++;
         $display("FAIL ram_writes got=%0d want=1", wcount);
      end
   endtask

   task automatic test_branch();
      exp_t e;
      sel0 = 1'b0; m = 3'b100; z = 1'b1;
      sum = 32'h40; alu = 32'h0;
      #1;
      total++;
      if ({pcs2, btg2} !== {1'b1, 32'h40}) begin
         bad++;
         $display("FAIL br_taken got=%b/%h want=1/40",
            pcs2, btg2);
      end
      z = 1'b0;
      #1;
      total++;
      if (pcs2 !== 1'b0) begin
         bad++;
         $display("FAIL br_nz got=%b want=0", pcs2);
      end
      @(posedge clk);
      #1;
      e = model(0, 2'b01, 3'b110, 32'h10, 32'h0, 5'd3, 1'b1);
      run_op(0, 2'b01, 3'b110, 32'h10, 32'h0, 5'd3, 1'b1, 1'b0);
      total++;
      if ({r_pcf, r_pcl} !== {e.pcf, e.pcl}) begin
         bad++;
         $display("FAIL br_ld_pc got=%b%b want=%b%b",
            r_pcf, r_pcl, e.pcf, e.pcl);
      end
      total++;
      if (r_d !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL br_ld_data got=%h want=deadbeef", r_d);
      end
   endtask

   task automatic test_misaligned();
      exp_t e;
      wcount = 0;
      e = model(0, 2'b11, 3'b010, 32'h13, 32'h0, 5'd5, 1'b0);
      run_op(0, 2'b11, 3'b010, 32'h13, 32'h0, 5'd5, 1'b0, 1'b0);
      total++;
      if ({r_mis, r_nst[1:0], r_w} !== {1'b1, 2'd0, 2'b00}) begin
         bad++;
         $display("FAIL mis_ld got=%b/%0d/%b want=1/0/00",
            r_mis, r_nst, r_w);
      end
      e = model(0, 2'b10, 3'b001, 32'h11,
         32'h5555, 5'd1, 1'b0);
      run_op(0, 2'b10, 3'b001, 32'h11,
         32'h5555, 5'd1, 1'b0, 1'b0);
      total++;
      if ({r_mis, r_nst[1:0]} !== {1'b1, 2'd0}) begin
         bad++;
         $display("FAIL mis_st got=%b/%0d want=1/0",
            r_mis, r_nst);
      end
      run_op(0, 2'b00, 3'b000, 32'h13, 32'h0, 5'd0, 1'b0, 1'b0);
      total++;
      if (r_mis !== 1'b0) begin
         bad++;
         $display("FAIL mis_pulse got=%b want=0", r_mis);
      end
      e = model(0, 2'b10, 3'b010, 32'h10, 32'h0, 5'd2, 1'b0);
      run_op(0, 2'b10, 3'b010, 32'h10, 32'h0, 5'd2, 1'b0, 1'b0);
      total++;
      if ({r_d, wcount[1:0]} !== {32'hDEADBEEF, 2'd0}) begin
         bad++;
         $display("FAIL mis_ram got=%h/%0d want=deadbeef/0",
            r_d, wcount);
      end
   endtask

   task automatic test_reset_wait();
      wcount = 0;
      sel0 = 1'b0; wb = 2'b00; m = 3'b001;
      alu = 32'h10; db = 32'h1234; z = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (stl2 !== 1'b1) begin
         bad++;
         $display("FAIL rw_wait got=%b want=1", stl2);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; m = 3'b000;
      #1;
      total++;
      if ({wbo2, dto2, alo2, mxo2, stl2} !== '0) begin
         bad++;
         $display("FAIL rw_clear got=%h want=0",
            {wbo2, dto2, alo2, mxo2, stl2});
      end
      @(posedge clk);
      #1;
      run_op(0, 2'b10, 3'b010, 32'h10, 32'h0, 5'd9, 1'b0, 1'b0);
      total++;
      if ({r_d, r_nst[1:0]} !== {32'hDEADBEEF, 2'd2}) begin
         bad++;
         $display("FAIL rw_old got=%h/%0d want=deadbeef/2",
            r_d, r_nst);
      end
      total++;
      if (wcount !== 0) begin
         bad++;
         $display("FAIL rw_nowrite got=%0d want=0", wcount);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      e = model(1, 2'b10, 3'b001, 32'h404,
         32'hCAFEF00D, 5'd3, 1'b0);
      run_op(1, 2'b10, 3'b001, 32'h404,
         32'hCAFEF00D, 5'd3, 1'b0, 1'b0);
      total++;
      if ({r_nst[1:0], r_w} !== {2'd0, 2'b10}) begin
         bad++;
         $display("FAIL l0_st got=%0d/%b want=0/10", r_nst, r_w);
      end
      e = model(1, 2'b11, 3'b010, 32'h404, 32'h0, 5'd4, 1'b0);
      run_op(1, 2'b11, 3'b010, 32'h404, 32'h0, 5'd4, 1'b0, 1'b0);
      total++;
      if ({r_d, r_nst[1:0]} !== {32'hCAFEF00D, 2'd0}) begin
         bad++;
         $display("FAIL l0_ld got=%h/%0d want=cafef00d/0",
            r_d, r_nst);
      end
      e = model(1, 2'b11, 3'b010, 32'h4, 32'h0, 5'd4, 1'b0);
      run_op(1, 2'b11, 3'b010, 32'h4, 32'h0, 5'd4, 1'b0, 1'b0);
      total++;
      if ({r_d, r_a} !== {32'hCAFEF00D, 32'h4}) begin
         bad++;
         $display("FAIL l0_wrap got=%h/%h want=cafef00d/4",
            r_d, r_a);
      end
      e = model(1, 2'b01, 3'b011, 32'h8,
         32'h0BADF00D, 5'd6, 1'b0);
      run_op(1, 2'b01, 3'b011, 32'h8,
         32'h0BADF00D, 5'd6, 1'b0, 1'b0);
      total++;
      if (r_d !== e.d) begin
         bad++;
         $display("FAIL l0_wthru got=%h want=%h", r_d, e.d);
      end
   endtask

   task automatic test_random();
      exp_t e;
      for (int i = 0; i < 40; i++) begin
         bit          s0;
         logic [1:0]  w;
         logic [2:0]  mm;
         logic [31:0] a, d;
         logic [4:0]  r;
         logic        zz;
         s0 = 1'($urandom_range(0, 1));
         w  = 2'($urandom);
         mm = 3'($urandom);
         d  = $urandom;
         r  = 5'($urandom);
         zz = 1'($urandom);
         a  = ($urandom & ~32'h3FF)
            | (32'($urandom_range(0, 15)) << 2);
         if ($urandom_range(0, 3) == 0)
            a[1:0] = 2'($urandom_range(1, 3));
         e = model(s0, w, mm, a, d, r, zz);
         run_op(s0, w, mm, a, d, r, zz, 1'b1);
         total++;
         if (r_nst !== e.nst) begin
            bad++;
            $display("FAIL rnd_stall[%0d] got=%0d want=%0d",
               i, r_nst, e.nst);
         end
         total++;
         if (r_mis !== e.mis) begin
            bad++;
            $display("FAIL rnd_mis[%0d] got=%b want=%b",
               i, r_mis, e.mis);
         end
         total++;
         if ({r_pcf, r_pcl} !== {e.pcf, e.pcl}) begin
            bad++;
            $display("FAIL rnd_pc[%0d] got=%b%b want=%b%b",
               i, r_pcf, r_pcl, e.pcf, e.pcl);
         end
         total++;
         if ({r_w, r_a, r_r} !== {e.w, e.a, e.r}) begin
            bad++;
            $display("FAIL rnd_ctl[%0d] got=%h want=%h",
               i, {r_w, r_a, r_r}, {e.w, e.a, e.r});
         end
         if (e.dchk) begin
            total++;
            if (r_d !== e.d) begin
               bad++;
               $display("FAIL rnd_data[%0d] got=%h want=%h",
                  i, r_d, e.d);
            end
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout got=running want=done");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; sel0 = 1'b0; wb = 0; m = 0;
      sum = 0; z = 0; alu = 0; db = 0; mux = 0;
      test_reset();
      test_store_load();
      test_branch();
      test_misaligned();
      test_reset_wait();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
